// File: rtl/weight_addr_gen_pkg.sv
// rtl/weight_addr_gen_pkg.sv - shared constants, state encoding and lane helper
// Purpose: widths, FSM states and the lane-slice helper used by the address
// generator, the address register file and its readers.
package weight_addr_gen_pkg;

  localparam int ADDR_W = 5;
  localparam int LANES  = 4;
  localparam int DIM_W  = ADDR_W + 1;
  // Kernel index compares need one more bit so kbase + LANES never wraps.
  localparam int KER_W  = DIM_W + 1;
  localparam int BUS_W  = LANES * ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] lane_slice(input logic [BUS_W-1:0] vec,
                                                   input int lane);
    return vec[lane*ADDR_W +: ADDR_W];
  endfunction

endpackage

// File: rtl/weight_addr_gen_if.sv
// rtl/weight_addr_gen_if.sv - address beat handshake bundle
// Purpose: one beat of packed per-lane row/col/ker addresses plus lane mask.
// Ports: out_valid/row_out/col_out/ker_out/lane_mask from the generator,
//        out_ready from the consumer (register file write enable side).
interface weight_addr_gen_if;

  logic                                  out_valid;
  logic                                  out_ready;
  logic [weight_addr_gen_pkg::BUS_W-1:0] row_out;
  logic [weight_addr_gen_pkg::BUS_W-1:0] col_out;
  logic [weight_addr_gen_pkg::BUS_W-1:0] ker_out;
  logic [weight_addr_gen_pkg::LANES-1:0] lane_mask;

  modport master (
    output out_valid, row_out, col_out, ker_out, lane_mask,
    input  out_ready
  );

  modport slave (
    input  out_valid, row_out, col_out, ker_out, lane_mask,
    output out_ready
  );

endinterface

// File: rtl/weight_addr_gen_addr_loop_counter.sv
// rtl/weight_addr_gen_addr_loop_counter.sv - nested col/row/kbase sweep counter
// Purpose: col innermost, then row, then kbase in steps of LANES.
// Ports: clock, reset (async active-low), clear (sync), step (advance one beat),
//        cfg_rows/cfg_cols/cfg_kers (latched dims), col/row/kbase, last.
module addr_loop_counter
  import weight_addr_gen_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic [DIM_W-1:0] cfg_cols,
  input  logic [DIM_W-1:0] cfg_kers,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic [KER_W-1:0] kbase,
  output logic             last
);

  logic col_last;
  logic row_last;
  logic ker_last;

  // Compare in KER_W bits so a dimension of 2^ADDR_W does not alias to 0.
  assign col_last = (KER_W'(col) + KER_W'(1)) == KER_W'(cfg_cols);
  assign row_last = (KER_W'(row) + KER_W'(1)) == KER_W'(cfg_rows);
  assign ker_last = (kbase + KER_W'(LANES)) >= KER_W'(cfg_kers);
  assign last     = col_last && row_last && ker_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col   <= '0;
      row   <= '0;
      kbase <= '0;
    end else if (clear) begin
      col   <= '0;
      row   <= '0;
      kbase <= '0;
    end else if (step) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row   <= '0;
          kbase <= kbase + KER_W'(LANES);
        end else begin
          row <= row + DIM_W'(1);
        end
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_addr_gen.sv
// rtl/weight_addr_gen.sv - weight-fetch address stream generator
// Purpose: sweeps kernel x row x column space, emitting one beat of LANES
// addresses per accepted handshake, masking lanes past the last kernel.
// Ports: clock, reset (async active-low), start, cfg_rows/cfg_cols/cfg_kers,
//        bus (out_valid/out_ready/row_out/col_out/ker_out/lane_mask),
//        busy (high in RUN), done (one-cycle pulse at sweep end).
module weight_addr_gen
  import weight_addr_gen_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [DIM_W-1:0]  cfg_kers,
  weight_addr_gen_if.master bus,
  output logic              busy,
  output logic              done
);

  state_t           state;
  state_t           state_nxt;
  logic [DIM_W-1:0] rows_q;
  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-1:0] kers_q;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;
  logic [KER_W-1:0] kbase;
  logic             last;
  logic             run;
  logic             load;
  logic             accept;
  logic             zero_dim;
  logic             unused_hi;

  assign run      = (state == ST_RUN);
  assign load     = (state == ST_IDLE) && start;
  assign accept   = run && bus.out_ready;
  assign zero_dim = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_kers == '0);

  // Address counters never exceed 2^ADDR_W-1, so their top bit is dead.
  assign unused_hi = ^{row[DIM_W-1], col[DIM_W-1], rows_q[0]};

  addr_loop_counter u_loop (
    .clock    (clock),
    .reset    (reset),
    .clear    (load),
    .step     (accept),
    .cfg_rows (rows_q),
    .cfg_cols (cols_q),
    .cfg_kers (kers_q),
    .col      (col),
    .row      (row),
    .kbase    (kbase),
    .last     (last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rows_q <= '0;
      cols_q <= '0;
      kers_q <= '0;
    end else if (load) begin
      rows_q <= cfg_rows;
      cols_q <= cfg_cols;
      kers_q <= cfg_kers;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = zero_dim ? ST_DONE : ST_RUN;
      ST_RUN:  if (accept && last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so out_valid has no path
  // from out_ready.
  assign bus.out_valid = run;
  assign busy          = run;
  assign done          = (state == ST_DONE);

  always_comb begin
    logic [KER_W-1:0] ker_idx;
    ker_idx       = '0;
    bus.row_out   = '0;
    bus.col_out   = '0;
    bus.ker_out   = '0;
    bus.lane_mask = '0;
    if (run) begin
      for (int i = 0; i < LANES; i++) begin
        ker_idx = kbase + KER_W'(i);
        bus.row_out[i*ADDR_W +: ADDR_W] = row[ADDR_W-1:0];
        bus.col_out[i*ADDR_W +: ADDR_W] = col[ADDR_W-1:0];
        if (ker_idx < KER_W'(kers_q)) begin
          bus.lane_mask[i]                = 1'b1;
          bus.ker_out[i*ADDR_W +: ADDR_W] = ker_idx[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_addr_gen.sv
// tb/tb_weight_addr_gen.sv - scoreboard bench for weight_addr_gen
module tb_weight_addr_gen;
  import weight_addr_gen_pkg::*;

  typedef struct packed {
    logic [BUS_W-1:0] row;
    logic [BUS_W-1:0] col;
    logic [BUS_W-1:0] ker;
    logic [LANES-1:0] mask;
  } beat_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [DIM_W-1:0] cfg_rows;
  logic [DIM_W-1:0] cfg_cols;
  logic [DIM_W-1:0] cfg_kers;
  logic             busy;
  logic             done;
  int               checks   = 0;
  int               failures = 0;
  beat_t            sb[$];

  weight_addr_gen_if bus();

  weight_addr_gen dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cfg_rows (cfg_rows),
    .cfg_cols (cfg_cols),
    .cfg_kers (cfg_kers),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic beat_t cur_beat();
    return {bus.row_out, bus.col_out, bus.ker_out, bus.lane_mask};
  endfunction

  task automatic push_model(input int rows, input int cols, input int kers);
    beat_t b;
    int    kk;
    for (int k = 0; k < kers; k += LANES)
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) begin
          b = '0;
          for (int i = 0; i < LANES; i++) begin
            b.row[i*ADDR_W +: ADDR_W] = r[ADDR_W-1:0];
            b.col[i*ADDR_W +: ADDR_W] = c[ADDR_W-1:0];
            kk = k + i;
            if (kk < kers) begin
              b.ker[i*ADDR_W +: ADDR_W] = kk[ADDR_W-1:0];
              b.mask[i] = 1'b1;
            end
          end
          sb.push_back(b);
        end
  endtask

  // Called at a negedge with the DUT idle. stall_at: 1-based beat held with
  // out_ready low for stall_len cycles; glitch_at: accepted count at which a
  // stray start with new cfg is driven; abort_at: return with that many beats
  // accepted (next beat on the bus).
  task automatic run_sweep(input int rows, input int cols, input int kers,
                           input int stall_at, input int stall_len,
                           input int glitch_at, input int abort_at);
    int acc = 0;
    int stall_left = 0;
    int cyc = 0;
    int nbeats;
    bit stalled = 0;
    bit glitched = 0;
    bit fin = 0;
    beat_t exp_b;
    push_model(rows, cols, kers);
    nbeats        = sb.size();
    cfg_rows      = DIM_W'(rows);
    cfg_cols      = DIM_W'(cols);
    cfg_kers      = DIM_W'(kers);
    bus.out_ready = 1'b1;
    start         = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    while (!fin && cyc < 3000) begin
      if (stall_at > 0 && !stalled && acc == stall_at - 1) begin
        stalled    = 1;
        stall_left = stall_len;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (abort_at >= 0 && acc == abort_at) return;
      if (bus.out_valid) begin
        chk("busy_in_run", 64'(busy), 64'd1);
        if (sb.size() == 0) begin
          chk("extra_beat", 64'(bus.out_valid), 64'd0);
        end else if (bus.out_ready) begin
          exp_b = sb.pop_front();
          chk($sformatf("beat%0d", acc + 1), 64'(cur_beat()), 64'(exp_b));
          acc++;
        end else begin
          chk("stall_hold", 64'(cur_beat()), 64'(sb[0]));
        end
      end else begin
        chk("end_state", {62'd0, sb.size() == 0, done}, 64'd3);
        fin = 1;
      end
      start = 1'b0;
      if (glitch_at >= 0 && !glitched && acc == glitch_at) begin
        glitched = 1;
        start    = 1'b1;
        cfg_rows = DIM_W'(1);
        cfg_cols = DIM_W'(1);
        cfg_kers = DIM_W'(1);
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (!fin) chk("timeout", 64'(fin), 64'd1);
    chk("done_one_cycle", {62'd0, done, bus.out_valid}, 64'd0);
    chk("beat_count", 64'(acc), 64'(nbeats));
    sb.delete();
  endtask

  initial begin
    int ndone;
    reset         = 1'b0;
    start         = 1'b0;
    cfg_rows      = '0;
    cfg_cols      = '0;
    cfg_kers      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_outs", {bus.row_out, bus.col_out, bus.ker_out, bus.lane_mask},
        64'd0);
    chk("reset_flags", {61'd0, bus.out_valid, busy, done}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // 3x3 kernel, one full lane group.
    run_sweep(3, 3, 4, 0, 0, -1, -1);
    // Two kernel groups, second one half masked.
    run_sweep(3, 3, 6, 0, 0, -1, -1);
    // Consumer stalls on beat 5 (row 1, col 1).
    run_sweep(3, 3, 4, 5, 3, -1, -1);

    // Zero dimension: done without any beat.
    cfg_rows = DIM_W'(3);
    cfg_cols = DIM_W'(0);
    cfg_kers = DIM_W'(4);
    start    = 1'b1;
    ndone    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'b0;
      chk("zero_no_valid", 64'(bus.out_valid), 64'd0);
      if (done) ndone++;
    end
    chk("zero_done_count", 64'(ndone), 64'd1);

    // Full 2^ADDR_W extent on rows and cols.
    run_sweep(32, 32, 4, 0, 0, -1, -1);
    // Stray start plus cfg change mid-sweep is ignored.
    run_sweep(3, 3, 5, 0, 0, 2, -1);

    // Asynchronous abort at beat 4, then a clean restart.
    run_sweep(3, 3, 4, 0, 0, -1, 3);
    #2 reset = 1'b0;
    #1;
    chk("abort_outs", {bus.row_out, bus.col_out, bus.ker_out, bus.lane_mask},
        64'd0);
    chk("abort_flags", {61'd0, bus.out_valid, busy, done}, 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done || bus.out_valid) ndone++;
    end
    chk("abort_no_resume", 64'(ndone), 64'd0);
    run_sweep(3, 3, 4, 0, 0, -1, -1);

    chk("lane_slice_fn", 64'(lane_slice(bus.ker_out, 1)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
